// File: rtl/fir_tap_reader.sv
// ---------------------------------------------------------------------------
// fir_tap_reader
//
// Reader end of the FIR sample buffer. Keeps a circular history of the last
// TAPS samples. The upstream writer supplies one new sample per window. After
// each accepted sample the full tap window is streamed to the MAC datapath,
// newest sample first, over a valid/ready handshake.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-high; clears storage, pointers and flags
//   enable    writer strobe; a sample is taken only while flags is low
//   data_in   sample from the writer
//   flags     busy; high while a window is being read, so the writer holds off
//   rd_data   current tap sample (combinational read of the history)
//   rd_valid  rd_data / rd_index / rd_last are valid
//   rd_ready  MAC accepts the current tap
//   rd_index  tap number, 0 = newest sample
//   rd_last   final tap of the window (rd_index == TAPS-1)
//   primed    at least TAPS samples accepted since reset
//   overrun   sticky; a write was attempted while flags was high
// ---------------------------------------------------------------------------
module fir_tap_reader #(
    parameter int WIDTH  = 32,
    parameter int TAPS   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [WIDTH-1:0]  data_in,
    output logic              flags,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_index,
    output logic              rd_last,
    output logic              primed,
    output logic              overrun
);

    // The write counter needs one extra bit so it can hold the value TAPS.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_TAP  = ADDR_W'(TAPS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(TAPS);
    localparam logic [ADDR_W-1:0] PTR_STEP  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_STEP  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mem [TAPS];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] tap_cnt;
    logic [CNT_W-1:0]  wr_count;
    logic              overrun_q;

    // Single controller for storage, pointers and the IDLE/READ sequencing.
    // A write in IDLE stores the sample, aims the read pointer at it and
    // starts a window. In READ each accepted tap walks the read pointer one
    // entry older (wrapping naturally since TAPS is a power of two) until
    // the last tap, which returns to IDLE. The tap counter is cleared on the
    // way out so rd_index reads 0 whenever no window is active.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tap_cnt   <= '0;
            wr_count  <= '0;
            overrun_q <= 1'b0;
            state     <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        mem[wr_ptr] <= data_in;
                        rd_ptr      <= wr_ptr;
                        wr_ptr      <= wr_ptr + PTR_STEP;
                        tap_cnt     <= '0;
                        state       <= READ;
                        if (wr_count != FULL_CNT) begin
                            wr_count <= wr_count + CNT_STEP;
                        end
                    end
                end
                READ: begin
                    // A write attempt while busy is dropped but remembered.
                    if (enable) begin
                        overrun_q <= 1'b1;
                    end
                    if (rd_ready) begin
                        if (tap_cnt == LAST_TAP) begin
                            tap_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            tap_cnt <= tap_cnt + PTR_STEP;
                            rd_ptr  <= rd_ptr - PTR_STEP;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All status outputs come straight from registered state, so there is
    // no combinational path from the writer strobe back to flags.
    always_comb begin
        flags    = (state == READ);
        rd_valid = (state == READ);
        rd_index = tap_cnt;
        rd_last  = (state == READ) && (tap_cnt == LAST_TAP);
        primed   = (wr_count == FULL_CNT);
        overrun  = overrun_q;
        rd_data  = mem[rd_ptr];
    end

endmodule

// File: tb/tb_fir_tap_reader.sv
module tb_fir_tap_reader;

    localparam int WIDTH  = 32;
    localparam int TAPS   = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [WIDTH-1:0]  data_in;
    logic              flags;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_index;
    logic              rd_last;
    logic              primed;
    logic              overrun;

    int vec_count  = 0;
    int miss_count = 0;

    fir_tap_reader #(.WIDTH(WIDTH), .TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .data_in  (data_in),
        .flags    (flags),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_index (rd_index),
        .rd_last  (rd_last),
        .primed   (primed),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a list of accepted samples (newest first), a busy
    // flag with the current beat number, a count of accepted samples and a
    // sticky overrun bit.
    logic [WIDTH-1:0] hist[$];
    bit               m_busy;
    int               m_beat;
    int               m_count;
    bit               m_over;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            m_busy  = 1'b0;
            m_beat  = 0;
            m_count = 0;
            m_over  = 1'b0;
        end else if (!m_busy) begin
            if (enable) begin
                hist.push_front(data_in);
                if (hist.size() > TAPS) void'(hist.pop_back());
                m_busy  = 1'b1;
                m_beat  = 0;
                m_count = m_count + 1;
            end
        end else begin
            if (enable) m_over = 1'b1;
            if (rd_ready) begin
                if (m_beat == TAPS - 1) m_busy = 1'b0;
                else m_beat = m_beat + 1;
            end
        end
    end

    function automatic logic [WIDTH-1:0] model_data();
        if (m_beat < hist.size()) return hist[m_beat];
        return '0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("flags", 32'(flags), 32'(m_busy));
            checkOutput("rd_valid", 32'(rd_valid), 32'(m_busy));
            checkOutput("rd_last", 32'(rd_last), 32'(m_busy && m_beat == TAPS - 1));
            checkOutput("primed", 32'(primed), 32'(m_count >= TAPS));
            checkOutput("overrun", 32'(overrun), 32'(m_over));
            if (m_busy) begin
                checkOutput("rd_index", 32'(rd_index), 32'(m_beat));
                checkOutput("rd_data", rd_data, model_data());
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (flags && n < 50) begin
            stepCycle();
            n++;
        end
        if (flags) checkOutput("idle_timeout", 32'(flags), 32'd0);
    endtask

    // Writes one sample once the buffer is free; returns in the cycle
    // where tap 0 of the new window is presented.
    task automatic applyStimulus(input logic [WIDTH-1:0] d);
        waitIdle();
        enable  = 1'b1;
        data_in = d;
        stepCycle();
        enable  = 1'b0;
        data_in = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        stepCycle();
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        data_in  = '0;
        rd_ready = 1'b1;
        stepCycle();
        checkOutput("reset_flags", 32'(flags), 32'd0);
        checkOutput("reset_rd_data", rd_data, 32'd0);
        checkOutput("reset_rd_index", 32'(rd_index), 32'd0);
        reset = 1'b0;
        stepCycle();

        // Single write into cleared storage.
        applyStimulus(32'h11);
        checkOutput("w1_valid", 32'(rd_valid), 32'd1);
        checkOutput("w1_index", 32'(rd_index), 32'd0);
        checkOutput("w1_data", rd_data, 32'h11);
        stepCycle();
        checkOutput("w1_tap1", rd_data, 32'd0);
        repeat (6) stepCycle();
        checkOutput("w1_last", 32'(rd_last), 32'd1);
        stepCycle();
        checkOutput("w1_done", 32'(flags), 32'd0);
        checkOutput("w1_primed", 32'(primed), 32'd0);

        // Fill the history with 1..8, then wrap with 9.
        doReset();
        for (int i = 1; i <= 8; i++) applyStimulus(32'(i));
        checkOutput("fill_primed", 32'(primed), 32'd1);
        checkOutput("fill_tap0", rd_data, 32'd8);
        repeat (7) stepCycle();
        checkOutput("fill_tap7", rd_data, 32'd1);
        applyStimulus(32'd9);
        checkOutput("wrap_tap0", rd_data, 32'd9);
        repeat (7) stepCycle();
        checkOutput("wrap_tap7", rd_data, 32'd2);

        // Back-pressure at tap 2.
        applyStimulus(32'h20);
        repeat (2) stepCycle();
        rd_ready = 1'b0;
        repeat (3) stepCycle();
        checkOutput("stall_index", 32'(rd_index), 32'd2);
        checkOutput("stall_data", rd_data, 32'd8);
        checkOutput("stall_valid", 32'(rd_valid), 32'd1);
        rd_ready = 1'b1;
        stepCycle();
        checkOutput("resume_index", 32'(rd_index), 32'd3);
        checkOutput("resume_data", rd_data, 32'd7);

        // Write attempted while busy.
        applyStimulus(32'h30);
        stepCycle();
        enable  = 1'b1;
        data_in = 32'hDEAD;
        stepCycle();
        enable  = 1'b0;
        data_in = '0;
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        applyStimulus(32'h31);
        checkOutput("overrun_tap1_pre", 32'(overrun), 32'd1);
        stepCycle();
        checkOutput("overrun_tap1", rd_data, 32'h30);
        waitIdle();
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);

        // Asynchronous reset in the middle of a window.
        applyStimulus(32'h40);
        repeat (4) stepCycle();
        #1;
        reset = 1'b1;
        #1;
        checkOutput("areset_flags", 32'(flags), 32'd0);
        checkOutput("areset_valid", 32'(rd_valid), 32'd0);
        checkOutput("areset_primed", 32'(primed), 32'd0);
        checkOutput("areset_overrun", 32'(overrun), 32'd0);
        stepCycle();
        reset = 1'b0;
        stepCycle();
        applyStimulus(32'h5);
        checkOutput("post_tap0", rd_data, 32'h5);
        stepCycle();
        checkOutput("post_tap1", rd_data, 32'd0);
        waitIdle();
        stepCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
